// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: feeds one full-adder cell with one bit of each
// operand per clock, LSB first, carrying between bits through a single flop.
// Parallel valid/ready handshakes on the operand and result sides.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter must be able to hold WIDTH itself, hence WIDTH+1 states.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Full-adder cell inputs and outputs.
  logic             fa_n_1;
  logic             fa_n_2;
  logic             fa_cin;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_sh_nxt;
  logic             last_bit;

  assign fa_n_1 = a_sh[0];
  assign fa_n_2 = b_sh[0];
  assign fa_cin = carry;

  // Full-adder cell: one bit of sum and the carry into the next bit.
  assign fa_sum  = fa_n_1 ^ fa_n_2 ^ fa_cin;
  assign fa_cout = (fa_n_1 & fa_n_2) | (fa_n_1 & fa_cin) | (fa_n_2 & fa_cin);

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
  // Written as shift/or so that WIDTH=1 needs no special case.
  assign sum_sh_nxt = (sum_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
  assign last_bit   = (cnt == CW'(WIDTH - 1));

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: every flop here is assigned with <= so all reads in this block
      // see pre-edge values; mixing in = would make ordering matter.
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_sh_nxt;
          carry  <= fa_cout;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            // Present the result straight from the next-state values so it
            // is valid in the same cycle out_valid rises.
            sum       <= sum_sh_nxt;
            cout      <= fa_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed testbench for serial_adder_ctrl (WIDTH=8) with hand-computed
// expected results.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;

  int total = 0;
  int bad   = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake an operand set, then wait for out_valid and check latency.
  task automatic start_and_wait(input string tag, input logic [7:0] va,
                                input logic [7:0] vb, input logic vc);
    int cycles;
    a        = va;
    b        = vb;
    cin      = vc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
    cycles = 1;
    while (!out_valid && cycles < 20) begin
      tick();
      if (!out_valid) cycles++;
    end
    check({tag, "_latency"}, 32'(cycles), 32'd8);
  endtask

  // Complete a full add: handshake, result check, output handshake.
  task automatic do_add(input string tag, input logic [7:0] va,
                        input logic [7:0] vb, input logic vc,
                        input logic [7:0] exp_sum, input logic exp_cout);
    start_and_wait(tag, va, vb, vc);
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_low"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic timing with zero operands.
    do_add("t1_zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    // Plain add with cin; out_ready held high throughout.
    out_ready = 1'b1;
    start_and_wait("t2_plain", 8'h3C, 8'h0F, 1'b1);
    check("t2_sum", 32'(sum), 32'h4C);
    check("t2_cout", 32'(cout), 32'd0);
    tick();
    out_ready = 1'b0;
    check("t2_in_ready_back", 32'(in_ready), 32'd1);
    check("t2_out_valid_low", 32'(out_valid), 32'd0);
    tick();
    // Result registers hold while idle.
    check("t2_idle_hold_sum", 32'(sum), 32'h4C);

    // Carry-in only, carry propagation, all ones.
    do_add("t_cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
    do_add("t3_carry", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    do_add("t4_ones", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Backpressure: inputs churn while the result is held.
    start_and_wait("t5_bp", 8'h55, 8'h22, 1'b0);
    for (int i = 0; i < 10; i++) begin
      a        = 8'(i * 37 + 1);
      b        = 8'(i * 91 + 5);
      cin      = i[0];
      in_valid = ~i[0];
      tick();
      check("t5_hold_sum", 32'(sum), 32'h77);
      check("t5_hold_cout", 32'(cout), 32'd0);
      check("t5_hold_in_ready", 32'(in_ready), 32'd0);
      check("t5_hold_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_release_in_ready", 32'(in_ready), 32'd1);
    do_add("t5_fresh", 8'hA0, 8'h70, 1'b1, 8'h11, 1'b1);

    // Reset during the third SHIFT cycle.
    a        = 8'h80;
    b        = 8'h80;
    cin      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("t6_rst_in_ready", 32'(in_ready), 32'd1);
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_sum", 32'(sum), 32'd0);
    check("t6_rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("t6_no_stale_result", 32'(out_valid), 32'd0);
    end
    do_add("t6_after", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
